// File: rtl/fft_sched_pkg.sv
// Shared types and helpers for the FFT twiddle-weight scheduler.
package fft_sched_pkg;

  localparam int data_width     = 16;
  localparam int bu_parallelism = 4;
  localparam int MAX_LENGTH     = 1024;

  localparam int MAX_DEPTH  = MAX_LENGTH / (2 * bu_parallelism);
  localparam int MAX_STAGES = $clog2(MAX_LENGTH);
  localparam int TW_ADDR_W  = $clog2(MAX_STAGES * MAX_DEPTH);
  localparam int STAGE_W    = $clog2(MAX_STAGES);
  localparam int LOG_W      = STAGE_W + 1;
  localparam int BEAT_W     = $clog2(MAX_DEPTH);
  localparam int DEPTH_W    = BEAT_W + 1;
  localparam int LANE_SHIFT = $clog2(2 * bu_parallelism);
  localparam int TW_W       = 2 * data_width * bu_parallelism;
  localparam int WDAT_W     = data_width * 4 * bu_parallelism;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN
  } state_e;

  typedef struct packed {
    logic [WDAT_W-1:0]  data;
    logic [STAGE_W-1:0] stage;
    logic               last;
  } beat_t;

  // A legal length is a power of two between one full beat and MAX_LENGTH.
  function automatic logic is_legal_length(input logic [15:0] len);
    return (len != 16'd0) &&
           ((len & (len - 16'd1)) == 16'd0) &&
           (len >= 16'(2 * bu_parallelism)) &&
           (len <= 16'(MAX_LENGTH));
  endfunction

  // Index of the highest set bit; equals log2 for a power of two.
  function automatic logic [LOG_W-1:0] log2_len(input logic [15:0] len);
    logic [LOG_W-1:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (len[i]) r = LOG_W'(i);
    end
    return r;
  endfunction

  // Spread each {imag, real} pair into a four-element lane: real, imag, 0, 0.
  function automatic logic [WDAT_W-1:0] pack_weights(input logic [TW_W-1:0] tw);
    logic [WDAT_W-1:0] w;
    w = '0;
    for (int k = 0; k < bu_parallelism; k++) begin
      w[4*data_width*k +: data_width]              = tw[2*data_width*k +: data_width];
      w[4*data_width*k + data_width +: data_width] = tw[2*data_width*k + data_width +: data_width];
    end
    return w;
  endfunction

endpackage

// File: rtl/fft_weight_skid.sv
// Two-entry beat FIFO between the twiddle memory return path and the weight port.
module fft_weight_skid
  import fft_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       push,
  input  beat_t      push_beat,
  input  logic       pop,
  output beat_t      head,
  output logic [1:0] count
);

  beat_t      r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;

  // Storage, pointers and occupancy; flush drops everything including a same-cycle push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) r_mem[i] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (push) begin
        r_mem[r_wr_ptr] <= push_beat;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;

endmodule

// File: rtl/fft_weight_scheduler.sv
// Walks every FFT stage, fetches twiddle beats and streams them to the butterfly weight port.
module fft_weight_scheduler
  import fft_sched_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 clr,
  input  logic [15:0]          length,
  output logic                 tw_rd_en,
  output logic [TW_ADDR_W-1:0] tw_rd_addr,
  input  logic [TW_W-1:0]      tw_rd_dat,
  output logic                 weight_vld,
  output logic [WDAT_W-1:0]    weight_dat,
  output logic [STAGE_W-1:0]   weight_stage,
  output logic                 weight_last,
  input  logic                 weight_rdy,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  state_e             r_state;
  state_e             w_state_next;
  logic [STAGE_W-1:0] r_stage;
  logic [BEAT_W-1:0]  r_beat;
  logic [LOG_W-1:0]   r_num_stages;
  logic [DEPTH_W-1:0] r_depth;
  logic               r_inflight;
  logic [STAGE_W-1:0] r_rd_stage;
  logic               r_rd_last;
  logic               r_done;
  logic               r_err;

  logic               w_issue;
  logic               w_accept;
  logic               w_done_set;
  logic               w_err_set;
  logic               w_room;
  logic               w_beat_wrap;
  logic               w_last_stage;
  logic               w_drained;
  logic               w_pop;
  logic [1:0]         w_count;
  beat_t              w_head;
  beat_t              w_push_beat;

  assign w_pop        = weight_vld & weight_rdy;
  assign w_room       = ({1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop}) < 3'd2;
  assign w_beat_wrap  = ({1'b0, r_beat} == (r_depth - DEPTH_W'(1)));
  assign w_last_stage = ({1'b0, r_stage} == (r_num_stages - LOG_W'(1)));
  assign w_drained    = ((w_count == 2'd0) || ((w_count == 2'd1) && w_pop)) && !r_inflight;

  // Next-state and per-cycle strobes; clr overrides every other decision.
  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    w_accept     = 1'b0;
    w_done_set   = 1'b0;
    w_err_set    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (is_legal_length(length)) begin
            w_accept     = 1'b1;
            w_state_next = ST_FETCH;
          end else begin
            w_err_set = 1'b1;
          end
        end
      end
      ST_FETCH: begin
        if (w_room) begin
          w_issue = 1'b1;
          if (w_beat_wrap && w_last_stage) w_state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_drained) begin
          w_done_set   = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
    if (clr) begin
      w_state_next = ST_IDLE;
      w_issue      = 1'b0;
      w_accept     = 1'b0;
      w_done_set   = 1'b0;
      w_err_set    = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Job parameters, stage/beat walk and the tag of the read currently in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage      <= '0;
      r_beat       <= '0;
      r_num_stages <= '0;
      r_depth      <= '0;
      r_inflight   <= 1'b0;
      r_rd_stage   <= '0;
      r_rd_last    <= 1'b0;
    end else if (clr) begin
      r_stage    <= '0;
      r_beat     <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_accept) begin
        r_stage      <= '0;
        r_beat       <= '0;
        r_num_stages <= log2_len(length);
        r_depth      <= DEPTH_W'(length >> LANE_SHIFT);
      end else if (w_issue) begin
        r_rd_stage <= r_stage;
        r_rd_last  <= w_beat_wrap;
        if (w_beat_wrap) begin
          r_beat  <= '0;
          r_stage <= w_last_stage ? '0 : r_stage + STAGE_W'(1);
        end else begin
          r_beat <= r_beat + BEAT_W'(1);
        end
      end
    end
  end

  // One-cycle done and err pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_done <= w_done_set;
      r_err  <= w_err_set;
    end
  end

  assign w_push_beat.data  = pack_weights(tw_rd_dat);
  assign w_push_beat.stage = r_rd_stage;
  assign w_push_beat.last  = r_rd_last;

  fft_weight_skid u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (clr),
    .push      (r_inflight),
    .push_beat (w_push_beat),
    .pop       (w_pop),
    .head      (w_head),
    .count     (w_count)
  );

  assign tw_rd_en     = w_issue;
  assign tw_rd_addr   = TW_ADDR_W'(r_stage) * TW_ADDR_W'(MAX_DEPTH) + TW_ADDR_W'(r_beat);
  assign weight_vld   = (w_count != 2'd0);
  assign weight_dat   = weight_vld ? w_head.data  : '0;
  assign weight_stage = weight_vld ? w_head.stage : '0;
  assign weight_last  = weight_vld & w_head.last;
  assign busy         = (r_state != ST_IDLE);
  assign done         = r_done;
  assign err          = r_err;

endmodule

// File: tb/tb_fft_weight_scheduler.sv
// Directed, table-driven bench for the FFT twiddle-weight scheduler.
module tb_fft_weight_scheduler;
  import fft_sched_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start;
  logic                 clr;
  logic [15:0]          length;
  logic                 tw_rd_en;
  logic [TW_ADDR_W-1:0] tw_rd_addr;
  logic [TW_W-1:0]      tw_rd_dat = '0;
  logic                 weight_vld;
  logic [WDAT_W-1:0]    weight_dat;
  logic [STAGE_W-1:0]   weight_stage;
  logic                 weight_last;
  logic                 weight_rdy;
  logic                 busy;
  logic                 done;
  logic                 err;

  fft_weight_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .clr          (clr),
    .length       (length),
    .tw_rd_en     (tw_rd_en),
    .tw_rd_addr   (tw_rd_addr),
    .tw_rd_dat    (tw_rd_dat),
    .weight_vld   (weight_vld),
    .weight_dat   (weight_dat),
    .weight_stage (weight_stage),
    .weight_last  (weight_last),
    .weight_rdy   (weight_rdy),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nChecks = 0;
  int nFails  = 0;
  int startCyc, firstVldCyc, doneCyc, errCyc, doneCnt, errCnt, maxCount;
  bit constPattern = 1'b0;
  bit randRdy = 1'b0;

  logic [TW_ADDR_W-1:0] qAddr[$];
  logic [WDAT_W-1:0]    qDat[$];
  logic [STAGE_W-1:0]   qStage[$];
  logic                 qLast[$];

  typedef struct {
    logic [15:0] len;
    bit          legal;
    int          beats;
    int          depth;
    int          doneAt;
  } vec_t;

  vec_t vecs[8];

  // Twiddle memory contents: each pair tagged with its lane and address.
  function automatic logic [TW_W-1:0] memWord(input logic [TW_ADDR_W-1:0] a);
    logic [TW_W-1:0] w;
    w = '0;
    for (int k = 0; k < bu_parallelism; k++) begin
      if (constPattern) begin
        w[32*k +: 32] = 32'h3C00_4000;
      end else begin
        w[32*k +: 16]      = {3'b000, 2'(k), a};
        w[32*k + 16 +: 16] = {3'b111, 2'(k), a};
      end
    end
    return w;
  endfunction

  // Expected beat for an address: lane k holds real, imag, 0, 0 from low to high.
  function automatic logic [WDAT_W-1:0] expDat(input logic [TW_ADDR_W-1:0] a);
    logic [WDAT_W-1:0] e;
    e = '0;
    for (int k = 0; k < bu_parallelism; k++) begin
      e[64*k +: 16]      = {3'b000, 2'(k), a};
      e[64*k + 16 +: 16] = {3'b111, 2'(k), a};
    end
    return e;
  endfunction

  always @(posedge clk) begin
    if (tw_rd_en) tw_rd_dat <= memWord(tw_rd_addr);
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (tw_rd_en) qAddr.push_back(tw_rd_addr);
      if (weight_vld && firstVldCyc < 0) firstVldCyc = cyc - startCyc;
      if (weight_vld && weight_rdy) begin
        qDat.push_back(weight_dat);
        qStage.push_back(weight_stage);
        qLast.push_back(weight_last);
      end
      if (done) begin
        doneCnt++;
        doneCyc = cyc - startCyc;
      end
      if (err) begin
        errCnt++;
        errCyc = cyc - startCyc;
      end
      if (int'(dut.w_count) > maxCount) maxCount = int'(dut.w_count);
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (randRdy) weight_rdy = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [WDAT_W-1:0] act,
                             input logic [WDAT_W-1:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] len);
    qAddr.delete();
    qDat.delete();
    qStage.delete();
    qLast.delete();
    firstVldCyc = -1;
    doneCyc     = -1;
    errCyc      = -1;
    doneCnt     = 0;
    errCnt      = 0;
    maxCount    = 0;
    length      = len;
    start       = 1'b1;
    startCyc    = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic waitDone(input string name, input int bound);
    int n = 0;
    while (doneCnt == 0 && n < bound) begin
      tick();
      n++;
    end
    checkOutput({name, " done within bound"}, WDAT_W'(doneCnt > 0), WDAT_W'(1));
    repeat (4) tick();
  endtask

  task automatic checkJob(input string name, input int expBeats, input int depth,
                          input int expFirst, input int expDone);
    int errs = 0;
    int nCmp;
    checkOutput({name, " beat count"}, WDAT_W'(qDat.size()), WDAT_W'(expBeats));
    checkOutput({name, " read count"}, WDAT_W'(qAddr.size()), WDAT_W'(expBeats));
    checkOutput({name, " done pulses"}, WDAT_W'(doneCnt), WDAT_W'(1));
    nCmp = expBeats;
    if (qDat.size() < nCmp) nCmp = qDat.size();
    if (qAddr.size() < nCmp) nCmp = qAddr.size();
    for (int i = 0; i < nCmp; i++) begin
      logic [TW_ADDR_W-1:0] ea;
      ea = TW_ADDR_W'((i / depth) * MAX_DEPTH + (i % depth));
      if (qAddr[i] !== ea || qDat[i] !== expDat(ea) ||
          qStage[i] !== STAGE_W'(i / depth) || qLast[i] !== ((i % depth) == depth - 1)) begin
        if (errs == 0)
          $display("[TB] %s first bad beat %0d: addr %0h stage %0d last %0b, want addr %0h",
                   name, i, qAddr[i], qStage[i], qLast[i], ea);
        errs++;
      end
    end
    checkOutput({name, " beat content errors"}, WDAT_W'(errs), WDAT_W'(0));
    if (expFirst >= 0)
      checkOutput({name, " first vld cycle"}, WDAT_W'(firstVldCyc), WDAT_W'(expFirst));
    if (expDone >= 0)
      checkOutput({name, " done cycle"}, WDAT_W'(doneCyc), WDAT_W'(expDone));
  endtask

  initial begin
    vecs[0] = '{16'd128,  1'b1, 112,  16,  115};
    vecs[1] = '{16'd8,    1'b1, 3,    1,   6};
    vecs[2] = '{16'd16,   1'b1, 8,    2,   11};
    vecs[3] = '{16'd32,   1'b1, 20,   4,   23};
    vecs[4] = '{16'd1024, 1'b1, 1280, 128, 1283};
    vecs[5] = '{16'd100,  1'b0, 0,    0,   0};
    vecs[6] = '{16'd2048, 1'b0, 0,    0,   0};
    vecs[7] = '{16'd4,    1'b0, 0,    0,   0};

    rst_n      = 1'b0;
    start      = 1'b0;
    clr        = 1'b0;
    length     = 16'd0;
    weight_rdy = 1'b1;
    repeat (3) tick();
    checkOutput("reset control outputs",
                WDAT_W'({tw_rd_en, tw_rd_addr, weight_vld, weight_stage, weight_last, busy, done, err}),
                WDAT_W'(0));
    checkOutput("reset weight_dat", weight_dat, '0);
    rst_n = 1'b1;
    repeat (2) tick();

    for (int v = 0; v < 8; v++) begin
      string nm;
      nm = $sformatf("len%0d", vecs[v].len);
      applyStimulus(vecs[v].len);
      if (vecs[v].legal) begin
        waitDone(nm, 3000);
        checkJob(nm, vecs[v].beats, vecs[v].depth, 3, vecs[v].doneAt);
      end else begin
        repeat (5) tick();
        checkOutput({nm, " err pulses"}, WDAT_W'(errCnt), WDAT_W'(1));
        checkOutput({nm, " err cycle"}, WDAT_W'(errCyc), WDAT_W'(1));
        checkOutput({nm, " reads"}, WDAT_W'(qAddr.size()), WDAT_W'(0));
        checkOutput({nm, " busy"}, WDAT_W'(busy), WDAT_W'(0));
      end
    end

    constPattern = 1'b1;
    applyStimulus(16'd8);
    waitDone("packing", 100);
    checkOutput("packing lanes", qDat.size() > 0 ? qDat[0] : '0,
                {4{64'h0000_0000_3C00_4000}});
    constPattern = 1'b0;

    randRdy = 1'b1;
    applyStimulus(16'd128);
    waitDone("backpressure", 5000);
    randRdy = 1'b0;
    #2;
    weight_rdy = 1'b1;
    checkJob("backpressure", 112, 16, 3, -1);
    checkOutput("backpressure max occupancy", WDAT_W'(maxCount <= 2), WDAT_W'(1));
    tick();

    applyStimulus(16'd128);
    for (int n = 0; n < 200 && qDat.size() < 40; n++) tick();
    checkOutput("abort reached beat 40", WDAT_W'(qDat.size() >= 40), WDAT_W'(1));
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checkOutput("abort busy low", WDAT_W'(busy), WDAT_W'(0));
    checkOutput("abort vld low", WDAT_W'(weight_vld), WDAT_W'(0));
    repeat (10) tick();
    checkOutput("abort no done", WDAT_W'(doneCnt), WDAT_W'(0));
    applyStimulus(16'd128);
    waitDone("after abort", 500);
    checkJob("after abort", 112, 16, 3, 115);

    applyStimulus(16'd128);
    for (int n = 0; n < 200 && qDat.size() < 20; n++) tick();
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("midjob reset control outputs",
                WDAT_W'({tw_rd_en, tw_rd_addr, weight_vld, weight_stage, weight_last, busy, done, err}),
                WDAT_W'(0));
    checkOutput("midjob reset weight_dat", weight_dat, '0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (10) tick();
    checkOutput("midjob reset no done", WDAT_W'(doneCnt), WDAT_W'(0));

    applyStimulus(16'd128);
    repeat (30) tick();
    length = 16'd8;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    length = 16'd128;
    waitDone("start ignored", 500);
    checkJob("start ignored", 112, 16, 3, 115);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
